// File: rtl/fft8_stream_adapter.sv
// Serial-to-parallel front end and parallel-to-serial back end around the 8-point FFT core.
// Latency: slot-7 accept to first bin is FFT_LAT+2 edges from IDLE; bins leave in natural order.
// Backpressure: s_ready drops while a full frame waits for capture; m_* hold while m_ready is low.
module fft8_stream_adapter #(
  parameter int FFT_LAT = 2,
  parameter int W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_re,
  input  logic [W-1:0]    s_im,
  input  logic            s_mode,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_re,
  output logic [W-1:0]    m_im,
  output logic [2:0]      m_idx,
  output logic            m_last,
  output logic [16*W-1:0] fft_x,
  output logic            fft_mode,
  input  logic [16*W-1:0] fft_y,
  output logic [15:0]     frame_cnt
);

  typedef struct packed {
    logic [W-1:0] im;
    logic [W-1:0] re;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LW = (FFT_LAT < 1) ? 1 : $clog2(FFT_LAT + 1);

  state_t        state;
  state_t        state_nxt;
  cplx_t [7:0]   ibuf;
  cplx_t [7:0]   obuf;
  logic [2:0]    in_cnt;
  logic [2:0]    out_idx;
  logic          in_full;
  logic          in_mode;
  logic [LW-1:0] lat_cnt;
  logic          s_hs;
  logic          load_wait;
  logic          capture;
  logic          drain_hs;

  assign s_ready = !in_full;
  assign s_hs    = s_valid && !in_full;
  // The input buffer feeds the core directly; it is frozen while in_full is set.
  assign fft_x   = ibuf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ibuf    <= '0;
      in_cnt  <= 3'd0;
      in_full <= 1'b0;
      in_mode <= 1'b0;
    end else begin
      if (s_hs) begin
        ibuf[in_cnt].re <= s_re;
        ibuf[in_cnt].im <= s_im;
        in_cnt          <= in_cnt + 3'd1;
        if (in_cnt == 3'd0) begin
          in_mode <= s_mode;
        end
        if (in_cnt == 3'd7) begin
          in_full <= 1'b1;
        end
      end else if (capture) begin
        in_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_wait = 1'b0;
    capture   = 1'b0;
    drain_hs  = 1'b0;
    m_valid   = 1'b0;
    m_re      = '0;
    m_im      = '0;
    m_idx     = 3'd0;
    m_last    = 1'b0;
    case (state)
      IDLE: begin
        if (in_full) begin
          state_nxt = WAIT;
          load_wait = 1'b1;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        m_valid  = 1'b1;
        m_re     = obuf[out_idx].re;
        m_im     = obuf[out_idx].im;
        m_idx    = out_idx;
        m_last   = (out_idx == 3'd7);
        drain_hs = m_ready;
        // in_full here is the pre-edge value, so a frame completing on this same edge waits in IDLE.
        if (m_ready && (out_idx == 3'd7)) begin
          if (in_full) begin
            state_nxt = WAIT;
            load_wait = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fft_mode  <= 1'b0;
      lat_cnt   <= '0;
      obuf      <= '0;
      out_idx   <= 3'd0;
      frame_cnt <= 16'd0;
    end else begin
      // fft_mode only moves on WAIT entry so the core sees one mode for the whole frame.
      if (load_wait) begin
        fft_mode <= in_mode;
        lat_cnt  <= LW'(FFT_LAT);
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LW'(1);
      end
      if (capture) begin
        obuf    <= fft_y;
        out_idx <= 3'd0;
      end else if (drain_hs) begin
        if (out_idx == 3'd7) begin
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          out_idx <= out_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft8_stream_adapter.sv
// Bench for fft8_stream_adapter: behavioural 8-point DFT core model, scoreboard of expected bins,
// directed frames from the test plan plus randomized frames with random gaps and random m_ready.
module tb_fft8_stream_adapter;

  localparam int W       = 16;
  localparam int FFT_LAT = 2;
  localparam int FW      = 16 * W;
  localparam real C      = 0.7071067811865476;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_re;
  logic [W-1:0]  s_im;
  logic          s_mode;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_re;
  logic [W-1:0]  m_im;
  logic [2:0]    m_idx;
  logic          m_last;
  logic [FW-1:0] fft_x;
  logic          fft_mode;
  logic [FW-1:0] fft_y;
  logic [15:0]   frame_cnt;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [2:0]   idx;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   fc_exp   = 0;
  bit   rand_rdy = 1'b0;

  fft8_stream_adapter #(.FFT_LAT(FFT_LAT), .W(W)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_mode(s_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_idx(m_idx), .m_last(m_last),
    .fft_x(fft_x), .fft_mode(fft_mode), .fft_y(fft_y), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real cosq(input int m);
    case (m)
      0: return 1.0;
      1: return C;
      2: return 0.0;
      3: return -C;
      4: return -1.0;
      5: return -C;
      6: return 0.0;
      default: return C;
    endcase
  endfunction

  function automatic real sinq(input int m);
    case (m)
      0: return 0.0;
      1: return C;
      2: return 1.0;
      3: return C;
      4: return 0.0;
      5: return -C;
      6: return -1.0;
      default: return -C;
    endcase
  endfunction

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Plain DFT: forward unscaled, inverse scaled by 1/8.
  function automatic logic [FW-1:0] dft8(input logic [FW-1:0] x, input logic inv);
    logic [FW-1:0] y;
    real ar, ai, xr, xi, cr, sr;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < 8; n++) begin
        xr = $itor($signed(x[2*W*n +: W]));
        xi = $itor($signed(x[2*W*n+W +: W]));
        cr = cosq((k * n) % 8);
        sr = sinq((k * n) % 8);
        if (!inv) begin
          ar = ar + xr * cr + xi * sr;
          ai = ai + xi * cr - xr * sr;
        end else begin
          ar = ar + xr * cr - xi * sr;
          ai = ai + xi * cr + xr * sr;
        end
      end
      if (inv) begin
        ar = ar / 8.0;
        ai = ai / 8.0;
      end
      y[2*W*k +: W]   = W'(rnd(ar));
      y[2*W*k+W +: W] = W'(rnd(ai));
    end
    return y;
  endfunction

  // Core model: registers its input, then its output.
  logic [FW-1:0] core_x_q;
  logic          core_mode_q;
  always @(posedge clk) begin
    core_x_q    <= fft_x;
    core_mode_q <= fft_mode;
    fft_y       <= dft8(core_x_q, core_mode_q);
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bin", {61'd0, m_idx}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("bin_re", m_re, e.re);
        chk("bin_im", m_im, e.im);
        chk("bin_idx", m_idx, e.idx);
        chk("bin_last", m_last, e.last);
      end
    end
  end

  task automatic put_sample(input logic [W-1:0] re, input logic [W-1:0] im, input logic md);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_re    = re;
    s_im    = im;
    s_mode  = md;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) chk("s_accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [FW-1:0] fr, input logic md, input bit toggle,
                            input bit gaps, input logic [FW-1:0] expv);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      put_sample(fr[2*W*k +: W], fr[2*W*k+W +: W], (toggle && k != 0) ? !md : md);
    end
    acc_cyc = cyc;
    for (int k = 0; k < 8; k++) begin
      e.re   = expv[2*W*k +: W];
      e.im   = expv[2*W*k+W +: W];
      e.idx  = 3'(k);
      e.last = (k == 7);
      exp_q.push_back(e);
    end
    fc_exp++;
  endtask

  task automatic wait_out(input string nm, input bit mode_chk);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (mode_chk) chk("fft_mode_hold", fft_mode, 1);
    end
    chk(nm, cyc - acc_cyc, FFT_LAT + 2);
  endtask

  task automatic wait_drained(input string nm);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) done = 1'b1;
    end
    chk({nm, "_drained"}, done, 1);
    chk({nm, "_frame_cnt"}, frame_cnt, fc_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_s_ready"}, s_ready, 1);
    chk({nm, "_m_valid"}, m_valid, 0);
    chk({nm, "_m_re"}, m_re, 0);
    chk({nm, "_m_im"}, m_im, 0);
    chk({nm, "_m_idx"}, m_idx, 0);
    chk({nm, "_m_last"}, m_last, 0);
    chk({nm, "_fft_x_zero"}, (fft_x == '0), 1);
    chk({nm, "_fft_mode"}, fft_mode, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, 0);
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < 16; k++) f[W*k +: W] = W'(int'($urandom_range(0, 2047)) - 1024);
    return f;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] fr, imp_exp, dc_fr, dc_exp;
    logic [W-1:0]  held_re;
    logic          md;
    int            c0, n;

    imp_exp = '0;
    dc_fr   = '0;
    dc_exp  = '0;
    for (int k = 0; k < 8; k++) begin
      imp_exp[2*W*k +: W] = 16'h0100;
      dc_fr[2*W*k +: W]   = 16'h0100;
    end
    dc_exp[W-1:0] = 16'h0800;

    reset = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0; s_mode = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Impulse, FFT.
    fr = '0;
    fr[W-1:0] = 16'h0100;
    send_frame(fr, 1'b0, 1'b0, 1'b0, imp_exp);
    wait_out("lat_idle", 1'b0);
    wait_drained("impulse");

    // DC.
    send_frame(dc_fr, 1'b0, 1'b0, 1'b0, dc_exp);
    wait_drained("dc");

    // IFFT impulse with mode hold check.
    fr = '0;
    fr[W-1:0] = 16'h0800;
    send_frame(fr, 1'b1, 1'b0, 1'b0, imp_exp);
    wait_out("lat_ifft", 1'b1);
    wait_drained("ifft");

    // Backpressure at idx 3 with a second DC frame overlapping the drain.
    fr = rand_frame();
    send_frame(fr, 1'b0, 1'b0, 1'b0, dft8(fr, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_valid && m_idx == 3'd2) && n < 100);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    fork
      begin
        @(negedge clk);
        held_re = m_re;
        repeat (5) begin
          chk("bp_idx_held", m_idx, 3);
          chk("bp_valid_held", m_valid, 1);
          chk("bp_re_held", m_re, held_re);
          @(posedge clk);
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
      send_frame(dc_fr, 1'b0, 1'b0, 1'b0, dc_exp);
    join
    chk("s_ready_full", s_ready, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!(m_valid && m_last && m_ready)) chk("s_ready_closed", s_ready, 0);
    end while (!(m_valid && m_last && m_ready) && n < 100);
    c0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!m_valid) chk("s_ready_closed_wait", s_ready, 0);
    end while (!m_valid && n < 100);
    chk("b2b_gap", cyc - c0, FFT_LAT + 2);
    chk("s_ready_reopen", s_ready, 1);
    wait_drained("overlap");

    // Mode latched on slot 0 only.
    fr = rand_frame();
    send_frame(fr, 1'b1, 1'b1, 1'b0, dft8(fr, 1'b1));
    wait_drained("toggle_ifft");
    fr = rand_frame();
    send_frame(fr, 1'b0, 1'b1, 1'b0, dft8(fr, 1'b0));
    wait_drained("toggle_fft");

    // Randomized frames, gaps and downstream stalls.
    rand_rdy = 1'b1;
    repeat (8) begin
      fr = rand_frame();
      md = 1'($urandom_range(0, 1));
      send_frame(fr, md, 1'b1, 1'b1, dft8(fr, md));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #3;
    m_ready = 1'b1;
    wait_drained("random");

    // Reset while in WAIT discards the frame.
    fr = '0;
    fr[W-1:0] = 16'h0800;
    send_frame(fr, 1'b1, 1'b0, 1'b0, imp_exp);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_mode", fft_mode, 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    exp_q.delete();
    fc_exp = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    fr = '0;
    fr[W-1:0] = 16'h0100;
    send_frame(fr, 1'b0, 1'b0, 1'b0, imp_exp);
    wait_out("lat_after_reset", 1'b0);
    wait_drained("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
